// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants: receiver FSM state
//                encoding, default frame geometry, and frame bit levels
//                common to the transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states; PARITY is only reachable when parity is built in
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Line levels of the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sipo_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_reg
//  Description : Serial-in / parallel-out shift register. Shifts right with
//                the serial bit entering the MSB, so an LSB-first stream
//                ends up in natural bit order after WIDTH shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_reg
    import uart_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] r_data;

    generate
        if (WIDTH == 1) begin : g_single
            // Single-bit register: the shift degenerates to a load
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (shift_en) begin
                    r_data <= serial_in;
                end
            end
        end else begin : g_multi
            // Right shift, new bit into the MSB
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (shift_en) begin
                    r_data <= {serial_in, r_data[WIDTH-1:1]};
                end
            end
        end
    endgenerate

    assign parallel_out = r_data;

endmodule : sipo_reg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Recovers start/data/stop frames from an
//                asynchronous line using an oversampling tick, samples each
//                bit at its centre, and presents bytes through a valid/ready
//                holding register with frame and overrun error pulses.
//                Define UART_RX_PARITY_EN to add an even-parity bit after
//                the data bits and drive parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_16x,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [TICK_W-1:0] c_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] c_TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  c_BIT_ONE   = BIT_W'(1);

    // Synchronizer
    logic r_rxd_meta;
    logic r_rxd_s;

    // FSM state and counters
    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_nxt;

    // Per-cycle strobes from the FSM
    logic w_shift_en;
    logic w_complete;
    logic w_accept;

    logic [DATA_BITS-1:0] w_shift_q;

`ifdef UART_RX_PARITY_EN
    logic r_parity_bit;
    logic w_parity_nxt;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // Data shift register, loaded one bit per data-bit centre sample
    sipo_reg #(
        .WIDTH (DATA_BITS)
    ) u_sipo (
        .clk          (clk),
        .rst          (rst),
        .shift_en     (w_shift_en),
        .serial_in    (r_rxd_s),
        .parallel_out (w_shift_q)
    );

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic: bit-centre sampling driven by the oversampling tick
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_en  = 1'b0;
        w_complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_nxt = r_parity_bit;
`endif
        case (r_state)
            S_IDLE: begin
                // Start edge is watched every clock for best phase accuracy
                if (r_rxd_s == START_BIT) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = '0;
                end
            end
            S_START: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        if (r_rxd_s == START_BIT) begin
                            w_state_nxt = S_DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                        end else begin
                            // Line went back high before mid-bit: glitch
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_cnt + c_BIT_ONE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_nxt   = '0;
                        w_parity_nxt = r_rxd_s;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
`endif
            S_STOP: begin
                if (baud_tick_16x) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        w_complete = 1'b1;
                        // A low stop bit may be a break: wait for idle
                        w_state_nxt = (r_rxd_s == STOP_BIT) ? S_IDLE : S_BREAK_WAIT;
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (r_rxd_s == STOP_BIT) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = rx_valid && rx_ready;
    assign rx_busy  = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);

    // Holding register, handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (w_complete) begin
                // A byte accepted this same cycle frees the slot for the new one
                if (!rx_valid || w_accept) begin
                    rx_data  <= w_shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
                frame_err <= (r_rxd_s != STOP_BIT);
            end else if (w_accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_complete && (^{w_shift_q, r_parity_bit});
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. One baud tick
//                every 4 clocks, 16 ticks per bit, so one bit = 64 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick_16x = 1'b0;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int checks   = 0;
    int failures = 0;

    // Observation counters, sampled on the falling edge
    int         valid_cnt = 0;
    int         fe_cnt    = 0;
    int         ovr_cnt   = 0;
    int         par_cnt   = 0;
    int         busy_cnt  = 0;
    logic [7:0] last_data = 8'h00;
    int         tick_div  = 0;

    int s_valid, s_fe, s_ovr, s_par, s_busy;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick_16x (baud_tick_16x),
        .rxd           (rxd),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    // Baud tick: one clock high out of every four
    always @(negedge clk) begin
        tick_div      = (tick_div == 3) ? 0 : tick_div + 1;
        baud_tick_16x = (tick_div == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = rx_data;
        end
        if (frame_err)   fe_cnt   = fe_cnt + 1;
        if (overrun_err) ovr_cnt  = ovr_cnt + 1;
        if (parity_err)  par_cnt  = par_cnt + 1;
        if (rx_busy)     busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = valid_cnt;
        s_fe    = fe_cnt;
        s_ovr   = ovr_cnt;
        s_par   = par_cnt;
        s_busy  = busy_cnt;
    endtask

    // Drives one frame; the line is left at stop_val afterwards
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic stop_val, input int stop_bits);
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        repeat (BIT_CLK) @(negedge clk);
`else
        if (par) begin
            // parity bit is not part of the frame in this build
        end
`endif
        rxd = stop_val;
        repeat (BIT_CLK * stop_bits) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid",   32'(rx_valid), 0);
        chk("reset_data",    32'(rx_data), 0);
        chk("reset_busy",    32'(rx_busy), 0);
        chk("reset_ferr",    32'(frame_err), 0);
        chk("reset_ovr",     32'(overrun_err), 0);
        chk("reset_par",     32'(parity_err), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy",     32'(rx_busy), 0);

        // 0xA5 with consumer always ready: one-cycle valid pulse
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("a5_valid_cycles", 32'(valid_cnt - s_valid), 1);
        chk("a5_data",         32'(last_data), 32'h A5);
        chk("a5_ferr",         32'(fe_cnt - s_fe), 0);
        chk("a5_ovr",          32'(ovr_cnt - s_ovr), 0);
        chk("a5_par",          32'(par_cnt - s_par), 0);
        chk("a5_busy_span",    32'((busy_cnt - s_busy) >= 600 && (busy_cnt - s_busy) <= 612), 1);
        chk("a5_busy_after",   32'(rx_busy), 0);
        chk("a5_valid_after",  32'(rx_valid), 0);

        // Back-to-back 0x3C, 0x81 with consumer stalled: overrun drops 0x81
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("ovr_first_valid", 32'(rx_valid), 1);
        chk("ovr_first_data",  32'(rx_data), 32'h3C);
        chk("ovr_first_none",  32'(ovr_cnt - s_ovr), 0);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("ovr_pulse",       32'(ovr_cnt - s_ovr), 1);
        chk("ovr_held_data",   32'(rx_data), 32'h3C);
        chk("ovr_held_valid",  32'(rx_valid), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_accept_clr",  32'(rx_valid), 0);

        // 0x55 with a low stop bit held for 3 bit times, then 0x12
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 3);
        chk("brk_ferr",        32'(fe_cnt - s_fe), 1);
        chk("brk_data",        32'(last_data), 32'h55);
        chk("brk_valid",       32'(valid_cnt - s_valid), 1);
        chk("brk_state",       32'(dut.r_state), 32'(S_BREAK_WAIT));
        snap();
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("brk_no_retrig",   32'(busy_cnt - s_busy), 0);
        chk("brk_busy",        32'(rx_busy), 0);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        snap();
        send_frame(8'h12, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("post_brk_data",   32'(last_data), 32'h12);
        chk("post_brk_valid",  32'(valid_cnt - s_valid), 1);
        chk("post_brk_ferr",   32'(fe_cnt - s_fe), 0);

        // Five-tick low glitch: START rejects it at mid-bit
        snap();
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("glitch_valid",    32'(valid_cnt - s_valid), 0);
        chk("glitch_busy_len", 32'((busy_cnt - s_busy) >= 20 && (busy_cnt - s_busy) <= 40), 1);
        chk("glitch_busy",     32'(rx_busy), 0);
        chk("glitch_state",    32'(dut.r_state), 32'(S_IDLE));

        // Reset in the middle of data bit 4
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        chk("midrst_busy_pre", 32'(rx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",     32'(rx_busy), 0);
        chk("midrst_data",     32'(rx_data), 0);
        chk("midrst_valid",    32'(rx_valid), 0);
        chk("midrst_errs",     32'({frame_err, overrun_err, parity_err}), 0);
        chk("midrst_state",    32'(dut.r_state), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4 * BIT_CLK) @(negedge clk);
        snap();
        send_frame(8'hF0, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("f0_data",         32'(last_data), 32'hF0);
        chk("f0_valid",        32'(valid_cnt - s_valid), 1);
        chk("f0_ferr",         32'(fe_cnt - s_fe), 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("par_bad_err",     32'(par_cnt - s_par), 1);
        chk("par_bad_data",    32'(last_data), 32'h07);
        chk("par_bad_valid",   32'(valid_cnt - s_valid), 1);
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1);
        repeat (16) @(negedge clk);
        chk("par_ok_err",      32'(par_cnt - s_par), 0);
        chk("par_ok_valid",    32'(valid_cnt - s_valid), 1);
`else
        chk("par_tied_low",    32'(par_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
